// File: rtl/mips_pkg.sv
// Shared fetch-stage types and instruction field positions.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;

    // Sequential word address, wrapping modulo 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr,pc} holding buffer for a fetch response that arrives while decode is stalled.
// Latency: one cycle from load to valid. Backpressure: the owner drains it only when the slot frees.
// Flush has priority over load, and load has priority over drain.
module fetch_skid_buf
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        vld,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld   <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= 32'h0;
        end else if (flush) begin
            vld <= 1'b0;
        end else if (load) begin
            vld   <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (drain) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, single-outstanding imem request, and the IF/ID slot.
// Latency: at least two cycles per instruction (REQ + WAIT). Backpressure: a stall parks one response in the skid.
// Redirect flushes the slot and skid. A response already in flight is killed so stale data never reaches decode.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [5:0]  opcode,
    output logic [5:0]  funct
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  inflight_pc;
    logic         kill;

    logic         skid_vld;
    logic [31:0]  skid_instr;
    logic [31:0]  skid_pc;

    logic         redirect_act;
    logic [31:0]  redirect_word;
    logic         slot_free;
    logic         resp_live;
    logic         load_slot;
    logic         load_skid;
    logic         drain_skid;

    // Redirect is ignored in IDLE because there is no fetch to restart.
    assign redirect_act  = redirect && (state != IDLE);
    assign redirect_word = {redirect_pc[31:2], 2'b00};
    assign slot_free     = !if_valid || !stall;
    assign resp_live     = (state == WAIT) && imem_rvalid && !kill && !redirect_act;
    assign load_slot     = resp_live && slot_free;
    assign load_skid     = resp_live && !slot_free;
    assign drain_skid    = (state == HOLD) && skid_vld && !stall && !redirect_act;

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;
    assign opcode    = if_instr[OPCODE_MSB:OPCODE_LSB];
    assign funct     = if_instr[FUNCT_MSB:FUNCT_LSB];

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_skid),
        .drain      (drain_skid),
        .flush      (redirect_act),
        .load_instr (imem_rdata),
        .load_pc    (inflight_pc),
        .vld        (skid_vld),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= {PC_RESET[31:2], 2'b00};
            inflight_pc <= 32'h0;
            kill        <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (redirect_act) begin
                        pc <= redirect_word;
                        if (imem_ready) begin
                            // The stale-address request is already accepted; its data must be dropped.
                            kill  <= 1'b1;
                            state <= WAIT;
                        end
                    end else if (imem_ready) begin
                        inflight_pc <= pc;
                        pc          <= pc_inc(pc);
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_act) begin
                        pc <= redirect_word;
                        if (imem_rvalid) begin
                            kill  <= 1'b0;
                            state <= REQ;
                        end else begin
                            kill <= 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= REQ;
                        end else if (slot_free) begin
                            state <= REQ;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_act) begin
                        pc    <= redirect_word;
                        state <= REQ;
                    end else if (!stall) begin
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid    <= 1'b0;
            if_instr    <= NOP_INSTR;
            if_pc       <= 32'h0;
            if_pc_plus4 <= 32'h0;
        end else if (redirect_act) begin
            if_valid <= 1'b0;
        end else if (load_slot) begin
            if_valid    <= 1'b1;
            if_instr    <= imem_rdata;
            if_pc       <= inflight_pc;
            if_pc_plus4 <= pc_inc(inflight_pc);
        end else if (drain_skid) begin
            if_valid    <= 1'b1;
            if_instr    <= skid_instr;
            if_pc       <= skid_pc;
            if_pc_plus4 <= pc_inc(skid_pc);
        end else if (!stall) begin
            if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed cycle-by-cycle checks of instr_fetch, plus a second instance with a wrapping reset PC.
module tb_instr_fetch;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    logic        rst5_n = 1'b0;
    logic        req5;
    logic [31:0] addr5;
    logic        ready5 = 1'b0;
    logic        rvalid5 = 1'b0;
    logic [31:0] rdata5 = 32'h0;
    logic        valid5;
    logic [31:0] instr5;
    logic [31:0] pc5;
    logic [31:0] pc5_plus4;
    logic [5:0]  opcode5;
    logic [5:0]  funct5;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    instr_fetch #(.PC_RESET(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_pc_plus4(if_pc_plus4), .opcode(opcode), .funct(funct)
    );

    instr_fetch #(.PC_RESET(32'hFFFF_FFFC)) dut5 (
        .clk(clk), .rst_n(rst5_n),
        .imem_req(req5), .imem_addr(addr5), .imem_ready(ready5),
        .imem_rvalid(rvalid5), .imem_rdata(rdata5),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .if_valid(valid5), .if_instr(instr5), .if_pc(pc5),
        .if_pc_plus4(pc5_plus4), .opcode(opcode5), .funct(funct5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        step();
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_pc4", if_pc_plus4, 32'h0);
        chk("rst_opcode", {26'b0, opcode}, 32'h0);
        chk("rst_funct", {26'b0, funct}, 32'h0);
        rst_n = 1'b1;

        // Basic fetch
        step();
        chk("t1_req0", {31'b0, imem_req}, 32'h1);
        chk("t1_addr0", imem_addr, 32'h0);
        imem_ready = 1'b1;
        step();
        chk("t1_wait_req", {31'b0, imem_req}, 32'h0);
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005;
        step();
        chk("t1_valid", {31'b0, if_valid}, 32'h1);
        chk("t1_instr", if_instr, 32'h2008_0005);
        chk("t1_pc", if_pc, 32'h0);
        chk("t1_pc4", if_pc_plus4, 32'h4);
        chk("t1_opcode", {26'b0, opcode}, 32'h08);
        chk("t1_funct", {26'b0, funct}, 32'h05);
        chk("t1_addr1", imem_addr, 32'h4);
        chk("t1_req1", {31'b0, imem_req}, 32'h1);
        imem_rvalid = 1'b0; imem_ready = 1'b1;
        step();
        chk("t1_drop_valid", {31'b0, if_valid}, 32'h0);
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0020;
        step();
        chk("t2_instr0", if_instr, 32'h0000_0020);
        chk("t2_pc0", if_pc, 32'h4);
        chk("t2_addr", imem_addr, 32'h8);

        // Stall while a response arrives
        stall = 1'b1; imem_rvalid = 1'b0; imem_ready = 1'b1;
        step();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h8C01_0004;
        step();
        chk("t2_hold_instr", if_instr, 32'h0000_0020);
        chk("t2_hold_valid", {31'b0, if_valid}, 32'h1);
        chk("t2_hold_req", {31'b0, imem_req}, 32'h0);
        chk("t2_state", {30'b0, dut.state}, {30'b0, HOLD});
        imem_rvalid = 1'b0;
        step();
        chk("t2_still_req", {31'b0, imem_req}, 32'h0);
        chk("t2_still_instr", if_instr, 32'h0000_0020);
        stall = 1'b0;
        step();
        chk("t2_instr1", if_instr, 32'h8C01_0004);
        chk("t2_pc1", if_pc, 32'h8);
        chk("t2_pc4", if_pc_plus4, 32'hC);
        chk("t2_opcode", {26'b0, opcode}, 32'h23);
        chk("t2_funct", {26'b0, funct}, 32'h04);
        chk("t2_next_addr", imem_addr, 32'hC);
        imem_ready = 1'b1;
        step();

        // Redirect in WAIT, response arrives later
        imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        chk("t3_valid", {31'b0, if_valid}, 32'h0);
        chk("t3_req", {31'b0, imem_req}, 32'h0);
        redirect = 1'b0;
        step();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        chk("t3_drop_valid", {31'b0, if_valid}, 32'h0);
        chk("t3_req_after", {31'b0, imem_req}, 32'h1);
        chk("t3_addr", imem_addr, 32'h0000_0100);

        // Redirect coincident with accept
        imem_rvalid = 1'b0; imem_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        chk("t4_wait_req", {31'b0, imem_req}, 32'h0);
        chk("t4_kill", {31'b0, dut.kill}, 32'h1);
        redirect = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        step();
        chk("t4_drop_valid", {31'b0, if_valid}, 32'h0);
        chk("t4_addr", imem_addr, 32'h0000_0200);
        chk("t4_req", {31'b0, imem_req}, 32'h1);
        imem_rvalid = 1'b0; imem_ready = 1'b1;
        step();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
        step();
        chk("t4_instr", if_instr, 32'h2222_2222);
        chk("t4_pc", if_pc, 32'h0000_0200);
        chk("t4_pc4", if_pc_plus4, 32'h0000_0204);
        chk("t4_next_addr", imem_addr, 32'h0000_0204);

        // Reset pulse mid-WAIT
        imem_rvalid = 1'b0; imem_ready = 1'b1;
        step();
        rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
        #1;
        chk("t6_req", {31'b0, imem_req}, 32'h0);
        chk("t6_valid", {31'b0, if_valid}, 32'h0);
        chk("t6_instr", if_instr, 32'h0);
        chk("t6_pc", if_pc, 32'h0);
        chk("t6_opcode", {26'b0, opcode}, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("t6_restart_req", {31'b0, imem_req}, 32'h1);
        chk("t6_restart_addr", imem_addr, 32'h0);
        chk("t6_late_valid", {31'b0, if_valid}, 32'h0);
        step();
        chk("t6_req_hold", {31'b0, imem_req}, 32'h1);
        chk("t6_late_valid2", {31'b0, if_valid}, 32'h0);
        imem_rvalid = 1'b0;

        // PC wrap with PC_RESET = 0xFFFF_FFFC
        rst5_n = 1'b1;
        step();
        chk("t5_addr0", addr5, 32'hFFFF_FFFC);
        chk("t5_req0", {31'b0, req5}, 32'h1);
        ready5 = 1'b1;
        step();
        ready5 = 1'b0; rvalid5 = 1'b1; rdata5 = 32'h0123_4567;
        step();
        chk("t5_pc", pc5, 32'hFFFF_FFFC);
        chk("t5_pc4", pc5_plus4, 32'h0);
        chk("t5_instr", instr5, 32'h0123_4567);
        chk("t5_addr1", addr5, 32'h0);
        chk("t5_req1", {31'b0, req5}, 32'h1);
        rvalid5 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
